// File: rtl/unary_parity_checker.sv
// Parity checker with a single-entry valid/ready output register.
// Every accepted word is passed through with an error flag. A saturating
// error counter and a sticky error flag track the errors, and clr clears both.
module unary_parity_checker #(
    parameter int unsigned N      = 8,
    parameter string       PARITY = "Odd",
    parameter int unsigned CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [N-1:0]  s_data,
    input  logic          s_parity,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [N-1:0]  m_data,
    output logic          m_err,
    input  logic          clr,
    output logic [CW-1:0] err_count,
    output logic          err_sticky
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam bit EVEN = (PARITY == "Even");

    state_t state;
    state_t state_nxt;
    logic   in_xfer;
    logic   out_xfer;
    logic   error;

    assign m_valid  = (state == FULL);
    assign s_ready  = !m_valid || m_ready;
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    // Odd sense flags an even number of ones over {data, parity}; Even sense flags an odd number.
    always_comb begin
        error = 1'b0;
        if (EVEN) error = ^{s_data, s_parity};
        else      error = ~^{s_data, s_parity};
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next occupancy: fill on accept; drain only when nothing refills the slot.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_xfer) state_nxt = FULL;
            FULL:    if (out_xfer && !in_xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output word register; it holds its value when drained or stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_err  <= 1'b0;
        end else if (in_xfer) begin
            m_data <= s_data;
            m_err  <= error;
        end
    end

    // Error statistics. clr wins over an error accepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (in_xfer && error) begin
            err_sticky <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule
